wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the asynchronous FIFO, the write-domain counterpart of the read-pointer/empty logic. It advances a binary write pointer on accepted writes and exports the Gray-coded pointer for synchronization into the read domain. It compares against the already-synchronized read Gray pointer to produce registered full, almost-full and occupancy outputs. It also tracks overflow attempts (writes issued while full) with a sticky flag and a saturating counter.

---
 rtl/wptr_full.sv | 97 +++++++++
 tb/tb_wptr_full.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-side pointer and full-flag generator for the asynchronous FIFO.
// Keeps the binary and Gray write pointers, the full/almost-full/level flags and an overflow tracker.
module wptr_full #(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_MARGIN = 2,
  parameter int OVF_CNT_W    = 8
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   rd_ptr_gray_sync,
  input  logic                 wovf_clr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr_gray,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 wovf,
  output logic [OVF_CNT_W-1:0] wovf_cnt
);

  localparam int                 DEPTH    = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AFULL_TH = (ADDR_SIZE+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [OVF_CNT_W-1:0] OVF_MAX = '1;

  logic [ADDR_SIZE:0]   wptr_bin;
  logic [ADDR_SIZE:0]   wptr_bin_next;
  logic [ADDR_SIZE:0]   wptr_gray_next;
  logic [ADDR_SIZE:0]   rbin_sync;
  logic [ADDR_SIZE:0]   wlevel_next;
  logic [ADDR_SIZE:0]   rd_gray_full;
  logic                 winc;
  logic                 ovf_evt;
  logic                 wfull_next;
  logic                 walmost_full_next;
  logic                 wovf_next;
  logic [OVF_CNT_W-1:0] wovf_cnt_next;

  assign winc    = wr_en & ~wfull;
  assign ovf_evt = wr_en & wfull;
  assign waddr   = wptr_bin[ADDR_SIZE-1:0];

  assign wptr_bin_next  = wptr_bin + (ADDR_SIZE+1)'(winc);
  assign wptr_gray_next = (wptr_bin_next >> 1) ^ wptr_bin_next;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign rd_gray_full = {~rd_ptr_gray_sync[ADDR_SIZE:ADDR_SIZE-1],
                         rd_ptr_gray_sync[ADDR_SIZE-2:0]};
  assign wfull_next   = (wptr_gray_next == rd_gray_full);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rbin_sync            = '0;
    rbin_sync[ADDR_SIZE] = rd_ptr_gray_sync[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ rd_ptr_gray_sync[i];
    end
  end

  assign wlevel_next       = wptr_bin_next - rbin_sync;
  assign walmost_full_next = (wlevel_next >= AFULL_TH);

  // A clear coincident with an event restarts the count at one instead of dropping the event.
  always_comb begin
    wovf_next     = wovf;
    wovf_cnt_next = wovf_cnt;
    if (wovf_clr) begin
      wovf_next     = ovf_evt;
      wovf_cnt_next = ovf_evt ? OVF_CNT_W'(1) : '0;
    end else if (ovf_evt) begin
      wovf_next     = 1'b1;
      wovf_cnt_next = (wovf_cnt == OVF_MAX) ? wovf_cnt : wovf_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wptr_bin     <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wovf         <= 1'b0;
      wovf_cnt     <= '0;
    end else begin
      wptr_bin     <= wptr_bin_next;
      wptr_gray    <= wptr_gray_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wlevel       <= wlevel_next;
      wovf         <= wovf_next;
      wovf_cnt     <= wovf_cnt_next;
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: vector table for the fill/overflow/read-advance path plus
// hand-written sequences for saturation, almost-full, wrap-around and mid-run reset.
module tb_wptr_full;

  localparam int AW = 4;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW:0]   rd_ptr_gray_sync = '0;
  logic          wovf_clr = 1'b0;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;
  logic [7:0]    wovf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wptr_full #(.ADDR_SIZE(AW), .AFULL_MARGIN(2), .OVF_CNT_W(8)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en),
    .rd_ptr_gray_sync(rd_ptr_gray_sync), .wovf_clr(wovf_clr),
    .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf), .wovf_cnt(wovf_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       we;
    logic [4:0] rdg;
    logic       clr;
    logic [3:0] e_addr;
    logic [4:0] e_gray;
    logic       e_full;
    logic       e_afull;
    logic [4:0] e_lvl;
    logic       e_ovf;
    logic [7:0] e_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [4:0] rdg, input logic clr, input logic rst);
    wr_en = we; rd_ptr_gray_sync = rdg; wovf_clr = clr; wr_rst = rst;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] a, input logic [4:0] g,
                           input logic f, input logic af, input logic [4:0] l,
                           input logic o, input logic [7:0] c);
    check({tag, ".waddr"}, 32'(waddr), 32'(a));
    check({tag, ".gray"},  32'(wptr_gray), 32'(g));
    check({tag, ".full"},  32'(wfull), 32'(f));
    check({tag, ".afull"}, 32'(walmost_full), 32'(af));
    check({tag, ".level"}, 32'(wlevel), 32'(l));
    check({tag, ".ovf"},   32'(wovf), 32'(o));
    check({tag, ".cnt"},   32'(wovf_cnt), 32'(c));
  endtask

  function automatic logic [4:0] gray(input int k);
    logic [4:0] b;
    b = 5'(k);
    return b ^ (b >> 1);
  endfunction

  vec_t vecs[12];
  logic [4:0] prev_gray;
  logic [4:0] diff;

  initial begin
    // State after 12 writes with rd pointer 0 is the starting point of this table.
    vecs[0]  = '{1'b1, 5'h00, 1'b0, 4'd13, 5'h0b, 1'b0, 1'b0, 5'd13, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 5'h00, 1'b0, 4'd14, 5'h09, 1'b0, 1'b1, 5'd14, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 5'h00, 1'b0, 4'd15, 5'h08, 1'b0, 1'b1, 5'd15, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 5'h00, 1'b0, 4'd0,  5'h18, 1'b1, 1'b1, 5'd16, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 5'h00, 1'b0, 4'd0,  5'h18, 1'b1, 1'b1, 5'd16, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 5'h00, 1'b1, 4'd0,  5'h18, 1'b1, 1'b1, 5'd16, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 5'h00, 1'b1, 4'd0,  5'h18, 1'b1, 1'b1, 5'd16, 1'b1, 8'd1};
    vecs[7]  = '{1'b0, 5'h00, 1'b1, 4'd0,  5'h18, 1'b1, 1'b1, 5'd16, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 5'h01, 1'b0, 4'd0,  5'h18, 1'b0, 1'b1, 5'd15, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 5'h01, 1'b0, 4'd1,  5'h19, 1'b1, 1'b1, 5'd16, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 5'h01, 1'b0, 4'd1,  5'h19, 1'b1, 1'b1, 5'd16, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 5'h01, 1'b1, 4'd1,  5'h19, 1'b1, 1'b1, 5'd16, 1'b0, 8'd0};

    // Reset with a write pending: the write must be ignored.
    step(1'b1, 5'h00, 1'b1, 1'b1);
    check_all("reset", 4'd0, 5'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);

    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 5'h00, 1'b0, 1'b0);
      check("fill.waddr", 32'(waddr), 32'(k));
      check("fill.gray", 32'(wptr_gray), 32'(gray(k)));
      check("fill.level", 32'(wlevel), 32'(k));
      check("fill.full", 32'(wfull), 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].we, vecs[i].rdg, vecs[i].clr, 1'b0);
      check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_gray, vecs[i].e_full,
                vecs[i].e_afull, vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_cnt);
    end

    // Overflow counter saturation, then clear alone, then clear with an event.
    for (int i = 0; i < 300; i++) step(1'b1, 5'h01, 1'b0, 1'b0);
    check_all("sat", 4'd1, 5'h19, 1'b1, 1'b1, 5'd16, 1'b1, 8'd255);
    step(1'b0, 5'h01, 1'b1, 1'b0);
    check("clr.ovf", 32'(wovf), 32'd0);
    check("clr.cnt", 32'(wovf_cnt), 32'd0);
    step(1'b1, 5'h01, 1'b1, 1'b0);
    check("clr_evt.ovf", 32'(wovf), 32'd1);
    check("clr_evt.cnt", 32'(wovf_cnt), 32'd1);

    // Almost-full threshold at level 14, released when the read pointer advances.
    step(1'b0, 5'h00, 1'b1, 1'b1);
    check_all("reset2", 4'd0, 5'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 5'h00, 1'b0, 1'b0);
      check("af.afull", 32'(walmost_full), (k >= 14) ? 32'd1 : 32'd0);
    end
    step(1'b0, 5'h01, 1'b0, 1'b0);
    check("af_rel.level", 32'(wlevel), 32'd13);
    check("af_rel.afull", 32'(walmost_full), 32'd0);
    check("af_rel.full", 32'(wfull), 32'd0);

    // Wrap-around with the read pointer trailing three writes behind.
    step(1'b0, 5'h00, 1'b0, 1'b1);
    prev_gray = wptr_gray;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, (i <= 3) ? 5'h00 : gray(i - 3), 1'b0, 1'b0);
      diff = wptr_gray ^ prev_gray;
      check("wrap.onebit", 32'($countones(diff)), 32'd1);
      check("wrap.waddr", 32'(waddr), 32'(i % 16));
      check("wrap.full", 32'(wfull), 32'd0);
      check("wrap.level", 32'(wlevel), (i <= 3) ? 32'(i) : 32'd3);
      if (i == 32) check("wrap.gray0", 32'(wptr_gray), 32'd0);
      prev_gray = wptr_gray;
    end

    // Mid-run reset with wr_en high, then the next write lands at address 0.
    step(1'b0, 5'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 5'h00, 1'b0, 1'b0);
    check("pre_rst.waddr", 32'(waddr), 32'd9);
    step(1'b1, 5'h00, 1'b0, 1'b1);
    check_all("midrst", 4'd0, 5'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
    wr_en = 1'b1; wr_rst = 1'b0;
    #1;
    check("post_rst.waddr", 32'(waddr), 32'd0);
    @(posedge wr_clk);
    #1;
    check("post_rst.next", 32'(waddr), 32'd1);
    check("post_rst.level", 32'(wlevel), 32'd1);
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
